mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-ported unified memory of the 64-bit full machine. It grants the memory port to either the instruction-fetch path or the load/store path and drives the memory for a fixed access latency. It returns a one-cycle acknowledge with registered read data and flags misaligned accesses, without touching memory, so the core can raise an exception. It sits between the fetch/MEM stages and the memory model, and its `stall` output freezes the PC register and the pipeline.

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and sequencer for the single-ported unified memory.
// Fetch and load/store alternate on ties; misaligned requests complete without touching memory.
module mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              last_grant_r;
    logic              owner_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              grant_s;
    logic              grant_d_s;
    logic              misalign_s;

    logic              if_ack_r;
    logic              if_err_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic              d_ack_r;
    logic              d_err_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    // Instructions are 32 bits; address bit 2 picks the half of the 64-bit word.
    function automatic logic [DATA_W-1:0] fetch_word(input logic upper, input logic [DATA_W-1:0] word);
        if (upper) begin
            fetch_word = {{(DATA_W-32){1'b0}}, word[63:32]};
        end else begin
            fetch_word = {{(DATA_W-32){1'b0}}, word[31:0]};
        end
    endfunction

    // Next-state logic and grant decision.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        grant_d_s    = GRANT_FETCH;
        misalign_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (if_req && (!d_req || (last_grant_r == GRANT_DATA))) begin
                    grant_s    = 1'b1;
                    grant_d_s  = GRANT_FETCH;
                    misalign_s = (if_addr[1:0] != 2'b00);
                end else if (d_req) begin
                    grant_s    = 1'b1;
                    grant_d_s  = GRANT_DATA;
                    misalign_s = (d_addr[2:0] != 3'b000);
                end else begin
                    grant_s    = 1'b0;
                end
                if (grant_s) begin
                    state_next_s = misalign_s ? DONE : ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant latching, access sequencing, read-data capture and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_r <= GRANT_DATA;
            owner_r      <= GRANT_FETCH;
            cnt_r        <= CNT_ZERO;
            if_ack_r     <= 1'b0;
            if_err_r     <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            d_ack_r      <= 1'b0;
            d_err_r      <= 1'b0;
            d_rdata_r    <= {DATA_W{1'b0}};
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
        end else begin
            if_ack_r <= 1'b0;
            if_err_r <= 1'b0;
            d_ack_r  <= 1'b0;
            d_err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        last_grant_r <= grant_d_s;
                        owner_r      <= grant_d_s;
                        if (misalign_s) begin
                            if_ack_r <= ~grant_d_s;
                            if_err_r <= ~grant_d_s;
                            d_ack_r  <= grant_d_s;
                            d_err_r  <= grant_d_s;
                        end else begin
                            cnt_r       <= CNT_LOAD;
                            mem_en_r    <= 1'b1;
                            mem_we_r    <= grant_d_s & d_we;
                            mem_addr_r  <= grant_d_s ? d_addr : if_addr;
                            mem_wdata_r <= grant_d_s ? d_wdata : {DATA_W{1'b0}};
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_r == CNT_ZERO) begin
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        if (owner_r == GRANT_DATA) begin
                            d_ack_r <= 1'b1;
                            // Stores keep the previous load data.
                            if (!mem_we_r) begin
                                d_rdata_r <= mem_rdata;
                            end
                        end else begin
                            if_ack_r   <= 1'b1;
                            if_rdata_r <= fetch_word(mem_addr_r[2], mem_rdata);
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DONE: begin
                    cnt_r <= CNT_ZERO;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_r;
    assign if_err    = if_err_r;
    assign if_rdata  = if_rdata_r;
    assign d_ack     = d_ack_r;
    assign d_err     = d_err_r;
    assign d_rdata   = d_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign stall     = (if_req & ~if_ack_r) | (d_req & ~d_ack_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized request pairs checked
// against a transaction-level model of arbitration order, latency and memory contents.
module tb_mem_arbiter;

    localparam int LAT0 = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_clear;
    logic        if_req, d_req, d_we;
    logic [63:0] if_addr, d_addr, d_wdata;

    logic        if_ack, if_err, d_ack, d_err, mem_en, mem_we, stall;
    logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_ack_1, if_err_1, d_ack_1, d_err_1, mem_en_1, mem_we_1, stall_1;
    logic [63:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT0)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut_lat1 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_1), .if_err(if_err_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack_1), .d_err(d_err_1), .d_rdata(d_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .stall(stall_1)
    );

    // Background contents of never-written words.
    function automatic logic [63:0] pat(input logic [7:0] i);
        pat = {24'h200800, i, 8'hA5, i, ~i, i ^ 8'h3C};
    endfunction

    // Memory device models (the second instance sees read-only background contents).
    logic [63:0] dev_mem [0:255];
    logic        dev_vld [0:255];
    assign mem_rdata   = dev_vld[mem_addr[10:3]] ? dev_mem[mem_addr[10:3]] : pat(mem_addr[10:3]);
    assign mem_rdata_1 = pat(mem_addr_1[10:3]);

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) dev_vld[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            dev_mem[mem_addr[10:3]] <= mem_wdata;
            dev_vld[mem_addr[10:3]] <= 1'b1;
        end
    end

    // Reference model state.
    logic [63:0] ref_mem [0:255];
    bit          ref_vld [0:255];
    bit          m_last_d;
    logic [63:0] m_if_rdata, m_d_rdata;
    int          e_if_cyc, e_d_cyc, e_en_n, e_we_n;
    bit          e_if_err, e_d_err;
    logic [63:0] e_if_rdata, e_d_rdata;

    // Observations from one transaction pair.
    int          o_if_n, o_if_cyc, o_d_n, o_d_cyc, o_en_n, o_en_first, o_we_n;
    logic        o_if_err, o_d_err;
    logic [63:0] o_if_rdata, o_d_rdata, o_en_addr;
    bit          o_both, o_timeout;
    logic [31:0] o_stall;

    function automatic logic [63:0] ref_read(input logic [7:0] i);
        ref_read = ref_vld[i] ? ref_mem[i] : pat(i);
    endfunction

    task automatic do_reset();
        reset = 1'b1; mem_clear = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 64'h0; d_addr = 64'h0; d_wdata = 64'h0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0; mem_clear = 1'b0;
        m_last_d = 1'b1; m_if_rdata = 64'h0; m_d_rdata = 64'h0;
        for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
    endtask

    // Transaction-level prediction: winner by alternation, then the other after it finishes.
    task automatic predict(input bit do_if, input logic [63:0] ia, input bit do_d,
                           input bit we, input logic [63:0] da, input logic [63:0] wd);
        int t;
        bit fetch_first, serve_d;
        logic [63:0] w;
        t = 0; e_if_cyc = -1; e_d_cyc = -1; e_if_err = 1'b0; e_d_err = 1'b0; e_en_n = 0; e_we_n = 0;
        fetch_first = do_if && (!do_d || m_last_d);
        for (int k = 0; k < 2; k++) begin
            serve_d = (k == 0) ? !fetch_first : fetch_first;
            if (serve_d && do_d) begin
                e_d_err = (da[2:0] != 3'b000);
                e_d_cyc = t + (e_d_err ? 1 : LAT0 + 1);
                if (!e_d_err) begin
                    e_en_n += LAT0;
                    if (we) begin
                        e_we_n += LAT0;
                        ref_mem[da[10:3]] = wd;
                        ref_vld[da[10:3]] = 1'b1;
                    end else begin
                        m_d_rdata = ref_read(da[10:3]);
                    end
                end
                m_last_d = 1'b1;
                t = e_d_cyc + 1;
            end else if (!serve_d && do_if) begin
                e_if_err = (ia[1:0] != 2'b00);
                e_if_cyc = t + (e_if_err ? 1 : LAT0 + 1);
                if (!e_if_err) begin
                    e_en_n += LAT0;
                    w = ref_read(ia[10:3]);
                    m_if_rdata = ia[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
                end
                m_last_d = 1'b0;
                t = e_if_cyc + 1;
            end
        end
        e_if_rdata = m_if_rdata;
        e_d_rdata  = m_d_rdata;
    endtask

    // Drives a request pair from a post-edge point; each requester drops its request after its ack.
    task automatic run_txn(input bit do_if, input logic [63:0] ia, input bit do_d,
                           input bit we, input logic [63:0] da, input logic [63:0] wd, input int budget);
        bit drop_if, drop_d;
        if_req = do_if; if_addr = ia; d_req = do_d; d_we = we; d_addr = da; d_wdata = wd;
        o_if_n = 0; o_if_cyc = -1; o_d_n = 0; o_d_cyc = -1; o_en_n = 0; o_en_first = -1; o_we_n = 0;
        o_if_err = 1'b0; o_d_err = 1'b0; o_if_rdata = 64'h0; o_d_rdata = 64'h0; o_en_addr = 64'h0;
        o_both = 1'b0; o_timeout = 1'b0; o_stall = 32'h0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (c < 32) o_stall[c] = stall;
            if (mem_en) begin
                o_en_n++;
                if (mem_we) o_we_n++;
                if (o_en_first < 0) begin o_en_first = c; o_en_addr = mem_addr; end
            end
            if (if_ack) begin o_if_n++; o_if_cyc = c; o_if_err = if_err; o_if_rdata = if_rdata; end
            if (d_ack) begin o_d_n++; o_d_cyc = c; o_d_err = d_err; o_d_rdata = d_rdata; end
            if (if_ack && d_ack) o_both = 1'b1;
            drop_if = if_ack; drop_d = d_ack;
            @(posedge clock);
            #1;
            if (drop_if) if_req = 1'b0;
            if (drop_d) d_req = 1'b0;
            if (!if_req && !d_req) break;
        end
        if (if_req || d_req) begin
            o_timeout = 1'b1;
            if_req = 1'b0; d_req = 1'b0;
            repeat (LAT0 + 2) @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        tests_run++;
        if ({if_ack, if_err, d_ack, d_err, mem_en, mem_we, stall} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000000", {if_ack, if_err, d_ack, d_err, mem_en, mem_we, stall});
        end
        tests_run++;
        if ({if_rdata, d_rdata} !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h %h want 0", if_rdata, d_rdata);
        end
        tests_run++;
        if ({mem_addr, mem_wdata} !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_mem_bus: got %h %h want 0", mem_addr, mem_wdata);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_single_fetch();
        logic [63:0] w;
        do_reset();
        w = pat(8'd2);
        predict(1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 64'h0);
        run_txn(1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 64'h0, 12);
        tests_run++;
        if (o_if_cyc !== 3 || o_if_n !== 1 || o_if_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_ack: got cyc %0d n %0d err %b want 3 1 0", o_if_cyc, o_if_n, o_if_err);
        end
        tests_run++;
        if (o_if_rdata !== {32'h0, w[31:0]}) begin
            tests_failed++;
            $display("FAIL fetch_rdata: got %h want %h", o_if_rdata, {32'h0, w[31:0]});
        end
        tests_run++;
        if (o_en_first !== 1 || o_en_n !== 2 || o_en_addr !== 64'h10 || o_we_n !== 0) begin
            tests_failed++;
            $display("FAIL fetch_mem_en: got first %0d n %0d addr %h we %0d want 1 2 10 0",
                     o_en_first, o_en_n, o_en_addr, o_we_n);
        end
        tests_run++;
        if (o_stall[3:0] !== 4'b0111) begin
            tests_failed++;
            $display("FAIL fetch_stall: got %b want 0111 (cycle 3..0)", o_stall[3:0]);
        end
    endtask

    task automatic test_store_load();
        do_reset();
        predict(1'b0, 64'h0, 1'b1, 1'b1, 64'h100, 64'hDEADBEEFCAFEF00D);
        run_txn(1'b0, 64'h0, 1'b1, 1'b1, 64'h100, 64'hDEADBEEFCAFEF00D, 12);
        tests_run++;
        if (o_we_n !== 2 || o_en_first !== 1 || o_en_addr !== 64'h100 || o_d_cyc !== 3) begin
            tests_failed++;
            $display("FAIL store_timing: got we %0d first %0d addr %h ack %0d want 2 1 100 3",
                     o_we_n, o_en_first, o_en_addr, o_d_cyc);
        end
        tests_run++;
        if (o_d_rdata !== e_d_rdata || o_d_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_keeps_rdata: got %h err %b want %h 0", o_d_rdata, o_d_err, e_d_rdata);
        end
        predict(1'b0, 64'h0, 1'b1, 1'b0, 64'h100, 64'h0);
        run_txn(1'b0, 64'h0, 1'b1, 1'b0, 64'h100, 64'h0, 12);
        tests_run++;
        if (o_d_rdata !== 64'hDEADBEEFCAFEF00D || o_we_n !== 0 || o_d_cyc !== 3) begin
            tests_failed++;
            $display("FAIL load_back: got %h we %0d ack %0d want deadbeefcafef00d 0 3", o_d_rdata, o_we_n, o_d_cyc);
        end
    endtask

    task automatic test_tie();
        do_reset();
        predict(1'b1, 64'h20, 1'b1, 1'b0, 64'h40, 64'h0);
        run_txn(1'b1, 64'h20, 1'b1, 1'b0, 64'h40, 64'h0, 16);
        tests_run++;
        if (o_if_cyc !== 3 || o_d_cyc !== 7 || o_both !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_after_reset: got if %0d d %0d both %b want 3 7 0", o_if_cyc, o_d_cyc, o_both);
        end
        predict(1'b1, 64'h28, 1'b0, 1'b0, 64'h0, 64'h0);
        run_txn(1'b1, 64'h28, 1'b0, 1'b0, 64'h0, 64'h0, 12);
        predict(1'b1, 64'h30, 1'b1, 1'b0, 64'h48, 64'h0);
        run_txn(1'b1, 64'h30, 1'b1, 1'b0, 64'h48, 64'h0, 16);
        tests_run++;
        if (o_d_cyc !== 3 || o_if_cyc !== 7) begin
            tests_failed++;
            $display("FAIL tie_alternates: got d %0d if %0d want 3 7", o_d_cyc, o_if_cyc);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        predict(1'b0, 64'h0, 1'b1, 1'b0, 64'h104, 64'h0);
        run_txn(1'b0, 64'h0, 1'b1, 1'b0, 64'h104, 64'h0, 8);
        tests_run++;
        if (o_d_cyc !== 1 || o_d_err !== 1'b1 || o_en_n !== 0 || o_d_n !== 1) begin
            tests_failed++;
            $display("FAIL misaligned_data: got ack %0d err %b en %0d n %0d want 1 1 0 1", o_d_cyc, o_d_err, o_en_n, o_d_n);
        end
        predict(1'b1, 64'h12, 1'b0, 1'b0, 64'h0, 64'h0);
        run_txn(1'b1, 64'h12, 1'b0, 1'b0, 64'h0, 64'h0, 8);
        tests_run++;
        if (o_if_cyc !== 1 || o_if_err !== 1'b1 || o_en_n !== 0 || o_if_n !== 1) begin
            tests_failed++;
            $display("FAIL misaligned_fetch: got ack %0d err %b en %0d n %0d want 1 1 0 1", o_if_cyc, o_if_err, o_en_n, o_if_n);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        do_reset();
        predict(1'b1, 64'h60, 1'b0, 1'b0, 64'h0, 64'h0);
        if_req = 1'b1; if_addr = 64'h60;
        @(posedge clock);
        #1;
        @(negedge clock);
        tests_run++;
        if (mem_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_before_reset: got mem_en %b want 1", mem_en);
        end
        reset = 1'b1; if_req = 1'b0;
        @(negedge clock);
        tests_run++;
        if (mem_en !== 1'b0 || if_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_after_reset: got mem_en %b if_ack %b want 0 0", mem_en, if_ack);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_last_d = 1'b1; m_if_rdata = 64'h0; m_d_rdata = 64'h0;
        acks = 0;
        repeat (6) begin
            @(negedge clock);
            if (if_ack) acks++;
        end
        tests_run++;
        if (acks !== 0) begin
            tests_failed++;
            $display("FAIL mid_ack_dropped: got %0d acks want 0", acks);
        end
        @(posedge clock);
        #1;
        predict(1'b1, 64'h68, 1'b1, 1'b0, 64'h70, 64'h0);
        run_txn(1'b1, 64'h68, 1'b1, 1'b0, 64'h70, 64'h0, 16);
        tests_run++;
        if (o_if_cyc !== 3 || o_d_cyc !== 7) begin
            tests_failed++;
            $display("FAIL mid_next_tie: got if %0d d %0d want 3 7", o_if_cyc, o_d_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int q1[$];
        int q0[$];
        logic [63:0] r1, w;
        do_reset();
        w = pat(8'd4);
        r1 = 64'h0;
        if_req = 1'b1; if_addr = 64'h24;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (if_ack_1) begin
                q1.push_back(c);
                r1 = if_rdata_1;
            end
            if (if_ack) q0.push_back(c);
            @(posedge clock);
            #1;
        end
        if_req = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        tests_run++;
        if (q1.size() !== 3) begin
            tests_failed++;
            $display("FAIL b2b_lat1_count: got %0d acks want 3", q1.size());
        end else begin
            tests_run++;
            if (q1[0] !== 2 || q1[1] !== 5 || q1[2] !== 8) begin
                tests_failed++;
                $display("FAIL b2b_lat1_cycles: got %0d %0d %0d want 2 5 8", q1[0], q1[1], q1[2]);
            end
        end
        tests_run++;
        if (r1 !== {32'h0, w[63:32]}) begin
            tests_failed++;
            $display("FAIL b2b_upper_half: got %h want %h", r1, {32'h0, w[63:32]});
        end
        tests_run++;
        if (q0.size() !== 2) begin
            tests_failed++;
            $display("FAIL b2b_lat2_count: got %0d acks want 2", q0.size());
        end else begin
            tests_run++;
            if (q0[0] !== 3 || q0[1] !== 7) begin
                tests_failed++;
                $display("FAIL b2b_lat2_cycles: got %0d %0d want 3 7", q0[0], q0[1]);
            end
        end
    endtask

    task automatic test_random();
        bit do_if, do_d, we;
        logic [63:0] ia, da, wd;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            do_if = 1'($urandom_range(0, 1));
            do_d  = 1'($urandom_range(0, 1));
            if (!do_if && !do_d) do_if = 1'b1;
            we = 1'($urandom_range(0, 1));
            ia = {56'h0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'b000};
            ia[2] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ia[1:0] = 2'($urandom_range(1, 3));
            da = {56'h0, 4'($urandom_range(0, 15)), 4'b0000} | {60'h0, 1'($urandom_range(0, 1)), 3'b000};
            if ($urandom_range(0, 3) == 0) da[2:0] = 3'($urandom_range(1, 7));
            wd = {$urandom, $urandom};
            predict(do_if, ia, do_d, we, da, wd);
            run_txn(do_if, ia, do_d, we, da, wd, 16);
            tests_run++;
            if (o_timeout !== 1'b0 || o_both !== 1'b0) begin
                tests_failed++;
                $display("FAIL rnd%0d_handshake: got timeout %b both %b want 0 0", n, o_timeout, o_both);
            end
            tests_run++;
            if (o_if_cyc !== e_if_cyc || o_d_cyc !== e_d_cyc) begin
                tests_failed++;
                $display("FAIL rnd%0d_ack_cycles: got if %0d d %0d want %0d %0d", n, o_if_cyc, o_d_cyc, e_if_cyc, e_d_cyc);
            end
            tests_run++;
            if (o_en_n !== e_en_n || o_we_n !== e_we_n) begin
                tests_failed++;
                $display("FAIL rnd%0d_mem_cycles: got en %0d we %0d want %0d %0d", n, o_en_n, o_we_n, e_en_n, e_we_n);
            end
            if (do_if) begin
                tests_run++;
                if (o_if_err !== e_if_err || o_if_rdata !== e_if_rdata) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_fetch: got err %b data %h want %b %h", n, o_if_err, o_if_rdata, e_if_err, e_if_rdata);
                end
            end
            if (do_d) begin
                tests_run++;
                if (o_d_err !== e_d_err || o_d_rdata !== e_d_rdata) begin
                    tests_failed++;
                    $display("FAIL rnd%0d_data: got err %b data %h want %b %h", n, o_d_err, o_d_rdata, e_d_err, e_d_rdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_tie();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
